// File: rtl/div_seq_ctrl.sv
// Execute-stage iterative divider sequencer: radix-2 restoring DIV/DIVU/REM/REMU with
// RISC-V special cases and pipeline stall. Optional early exit via `DIV_SEQ_EARLY_EXIT_EN.
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_index_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [4:0]      rd_index_o
);

  // Handshake: a request is taken when start_i=1 and flush_i=0 while the sequencer is
  // in IDLE or DONE; while busy (CALC/FIX) start_i is ignored and decode is stalled.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_abs_q, b_abs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic              a_neg_q, a_neg_d;
  logic              q_neg_q, q_neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic              early_q, early_d;
  logic [4:0]        rd_req_q, rd_req_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Operand conditioning at acceptance
  logic              in_signed;
  logic              in_a_neg;
  logic              in_b_neg;
  logic [XLEN-1:0]   in_a_abs;
  logic [XLEN-1:0]   in_b_abs;
  logic              in_div0;
  logic              in_ovf;
  logic              in_early;

  assign in_signed = ~op_i[0];
  assign in_a_neg  = in_signed & a_i[XLEN-1];
  assign in_b_neg  = in_signed & b_i[XLEN-1];
  assign in_a_abs  = in_a_neg ? (~a_i + 1'b1) : a_i;
  assign in_b_abs  = in_b_neg ? (~b_i + 1'b1) : b_i;
  assign in_div0   = (b_i == '0);
  assign in_ovf    = in_signed && (a_i == MIN_NEG) && (b_i == '1);

`ifdef DIV_SEQ_EARLY_EXIT_EN
  assign in_early  = !in_div0 && (in_a_abs < in_b_abs);
`else
  assign in_early  = 1'b0;
`endif

  // One restoring step: the shifted partial remainder needs XLEN+1 bits, but once the
  // subtraction is taken the difference is always below |b| and fits in XLEN bits.
  logic [XLEN:0]     step_sh;
  logic              step_ge;
  logic [XLEN-1:0]   step_diff;

  assign step_sh   = {rem_q, quo_q[XLEN-1]};
  assign step_ge   = (step_sh >= {1'b0, b_abs_q});
  assign step_diff = step_sh[XLEN-1:0] - b_abs_q;

  // Result selection in FIX
  logic [XLEN-1:0]   fix_quo;
  logic [XLEN-1:0]   fix_rem;
  logic [XLEN-1:0]   fix_sel;

  always_comb begin
    fix_quo = '0;
    fix_rem = '0;
    if (div0_q) begin
      fix_quo = '1;
      fix_rem = a_q;
    end else if (ovf_q) begin
      fix_quo = MIN_NEG;
      fix_rem = '0;
    end else if (early_q) begin
      fix_quo = '0;
      fix_rem = a_q;
    end else begin
      fix_quo = q_neg_q ? (~quo_q + 1'b1) : quo_q;
      fix_rem = a_neg_q ? (~rem_q + 1'b1) : rem_q;
    end
  end

  assign fix_sel = op_q[1] ? fix_rem : fix_quo;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_abs_d  = b_abs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    a_neg_d  = a_neg_q;
    q_neg_d  = q_neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    early_d  = early_q;
    rd_req_d = rd_req_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && !flush_i) begin
          op_d     = op_i;
          a_d      = a_i;
          b_abs_d  = in_b_abs;
          rem_d    = '0;
          quo_d    = in_a_abs;
          a_neg_d  = in_a_neg;
          q_neg_d  = in_a_neg ^ in_b_neg;
          div0_d   = in_div0;
          ovf_d    = in_ovf;
          early_d  = in_early;
          rd_req_d = rd_index_i;
          if (in_div0 || in_ovf || in_early) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_ge ? step_diff : step_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], step_ge};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_sel;
          rd_out_d = rd_req_q;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_abs_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      early_q  <= 1'b0;
      rd_req_q <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_abs_q  <= b_abs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      a_neg_q  <= a_neg_d;
      q_neg_q  <= q_neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      early_q  <= early_d;
      rd_req_q <= rd_req_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Stall, busy and strobe decode registered state only, so no input reaches them.
  assign busy_o         = (state_q == S_CALC) || (state_q == S_FIX);
  assign stall_o        = busy_o;
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = result_q;
  assign rd_index_o     = rd_out_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus randomized operations
// against an arithmetic reference model, with latency, stall and flush checks.
module tb_div_seq_ctrl;
  localparam int XLEN = 32;
`ifdef DIV_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            reset_ni;
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [4:0]      rd_index_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;
  logic [4:0]      rd_index_o;

  div_seq_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .start_i        (start_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .rd_index_i     (rd_index_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .rd_index_o     (rd_index_o)
  );

  // Scoreboard
  logic [XLEN-1:0] exp_q[$];
  logic [4:0]      exp_rd_q[$];
  logic [XLEN-1:0] last_res;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic                   ovf;
    sa  = a;
    sb  = b;
    ovf = (sa == -(2**(XLEN-1))) && (sb == -1);
    case (op)
      2'd0:    model = (b == 0) ? '1 : ovf ? a : XLEN'(sa / sb);
      2'd1:    model = (b == 0) ? '1 : a / b;
      2'd2:    model = (b == 0) ? a  : ovf ? '0 : XLEN'(sa % sb);
      default: model = (b == 0) ? a  : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic [XLEN-1:0] ma;
    logic [XLEN-1:0] mb;
    bit              sgn;
    sgn = (op[0] == 1'b0);
    ma  = (sgn && a[XLEN-1]) ? (0 - a) : a;
    mb  = (sgn && b[XLEN-1]) ? (0 - b) : b;
    if (b == 0) return 1'b1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return EARLY && (ma < mb);
  endfunction

  // Drivers (called positioned at a negedge; return at a negedge)
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("idle_valid", {31'b0, result_valid_o}, 0);
      check("idle_stall", {31'b0, stall_o}, 0);
    end
  endtask

  // Presents one request at cycle 0; flush_cyc>0 flushes during that cycle.
  // Returns at the negedge of the strobe cycle (so a back-to-back start can follow).
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd, input int flush_req);
    int  cyc;
    int  valid_cyc;
    int  stall_cnt;
    int  exp_lat;
    int  flush_cyc;
    int  max_cyc;
    exp_lat   = is_special(op, a, b) ? 2 : XLEN + 2;
    flush_cyc = (flush_req > exp_lat - 1) ? exp_lat - 1 : flush_req;
    max_cyc   = (flush_cyc > 0) ? flush_cyc + 2 : XLEN + 8;
    start_i    = 1'b1;
    op_i       = op;
    a_i        = a;
    b_i        = b;
    rd_index_i = rd;
    check("accept_stall", {31'b0, stall_o}, 0);
    @(posedge clk_i);
    if (flush_cyc == 0) begin
      exp_q.push_back(model(op, a, b));
      exp_rd_q.push_back(rd);
    end
    @(negedge clk_i);
    start_i    = 1'b0;
    op_i       = 2'($urandom);
    a_i        = $urandom;
    b_i        = $urandom;
    rd_index_i = 5'($urandom);
    cyc       = 1;
    valid_cyc = 0;
    stall_cnt = 0;
    while (cyc <= max_cyc && valid_cyc == 0) begin
      flush_i = (flush_cyc != 0 && cyc == flush_cyc);
      if (stall_o) stall_cnt++;
      if (result_valid_o) begin
        valid_cyc = cyc;
        if (flush_cyc != 0 || exp_q.size() == 0) begin
          check("unexpected_strobe", {31'b0, result_valid_o}, 0);
        end else begin
          check("result", result_o, exp_q.pop_front());
          check("rd_index", {27'b0, rd_index_o}, {27'b0, exp_rd_q.pop_front()});
          last_res = result_o;
        end
      end else begin
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        cyc++;
      end
    end
    if (flush_cyc != 0) begin
      check("flush_stall_cycles", stall_cnt, flush_cyc);
      check("flush_no_strobe", valid_cyc, 0);
    end else begin
      check("latency", valid_cyc, exp_lat);
      check("stall_cycles", stall_cnt, exp_lat - 1);
    end
  endtask

  initial begin
    int mode;
    int flush_req;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int strobes;

    reset_ni   = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = '0;
    a_i        = '0;
    b_i        = '0;
    rd_index_i = '0;
    last_res   = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", {31'b0, stall_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_valid", {31'b0, result_valid_o}, 0);
    check("rst_result", result_o, 0);
    check("rst_rd", {27'b0, rd_index_o}, 0);
    reset_ni = 1'b1;
    idle(1);

    // Directed cases
    run_op(2'd1, 32'd100, 32'd7, 5'd9, 0);
    idle(1);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
    run_op(2'd1, 32'd5, 32'd0, 5'd3, 0);
    run_op(2'd3, 32'd5, 32'd0, 5'd4, 0);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
    run_op(2'd1, 32'd3, 32'd10, 5'd7, 0);
    run_op(2'd2, 32'hFFFF_FFFD, 32'd10, 5'd8, 0);
    idle(1);
    run_op(2'd1, 32'd100, 32'd7, 5'd10, 10);
    run_op(2'd1, 32'd100, 32'd7, 5'd11, 0);
    run_op(2'd1, 32'd100, 32'd7, 5'd12, 0);
    idle(3);
    check("result_hold", result_o, last_res);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom);
      mode = $urandom_range(0, 5);
      case (mode)
        0:       begin a = $urandom; b = $urandom; end
        1:       begin a = $urandom; b = 32'($urandom_range(1, 300)); end
        2:       begin a = $urandom; b = 32'd0; end
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       begin a = 32'($urandom_range(0, 50)); b = $urandom; end
        default: begin a = 0 - 32'($urandom_range(1, 1000)); b = 0 - 32'($urandom_range(1, 40)); end
      endcase
      flush_req = ($urandom_range(0, 5) == 0) ? $urandom_range(1, XLEN + 1) : 0;
      run_op(op, a, b, 5'($urandom), flush_req);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    // Reset in the middle of an operation abandons it silently
    start_i = 1'b1;
    op_i    = 2'd1;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    reset_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    check("midrst_stall", {31'b0, stall_o}, 0);
    check("midrst_result", result_o, 0);
    check("midrst_rd", {27'b0, rd_index_o}, 0);
    strobes = 0;
    for (int i = 0; i < XLEN + 6; i++) begin
      @(negedge clk_i);
      if (result_valid_o) strobes++;
    end
    check("midrst_no_strobe", strobes, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequencer for the execute-stage iterative divider. It accepts one DIV/DIVU/REM/REMU request, runs a radix-2 restoring shift-subtract datapath for XLEN iterations, and applies RISC-V special-case and sign fix-up. It drives the pipeline stall that freezes fetch/decode (ex_stall_w) and returns a one-cycle result strobe with the destination register index.

Parameters:
XLEN, 32, operand/result width; must be a power of two ≥ 8.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk_i  input  1  clock, all logic on rising edge
reset_ni  input  1  synchronous active-low reset
start_i  input  1  divide request valid (decode alu_op == ALU_DIV)
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
a_i  input  XLEN  dividend (rs1)
b_i  input  XLEN  divisor (rs2)
rd_index_i  input  5  destination register
flush_i  input  1  pipeline flush / branch-taken abort
stall_o  output  1  pipeline stall (ex_stall_w)
busy_o  output  1  operation in progress (CALC or FIX)
result_o  output  XLEN  quotient or remainder
result_valid_o  output  1  one-cycle result strobe
rd_index_o  output  5  destination for result_o

Behaviour:
- Reset (reset_ni==0 at a clock edge): state=IDLE, counter=0, stall_o=0, busy_o=0, result_valid_o=0, result_o=0, rd_index_o=0. Reset mid-operation abandons the operation with no strobe.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 and flush_i=0: latch op, |a|, |b|, sign flags (signed ops only), rd_index. Next state:
  - FIX if b==0 or signed overflow (a==2^(XLEN-1), b==all-ones, op DIV/REM);
  - FIX if early exit applies (see Optional Feature);
  - otherwise CALC with counter=XLEN.
- Acceptance cycle: stall_o=0; the request instruction advances normally.
- CALC: each cycle shift {rem,quo} left by 1; if rem ≥ |b|, subtract and set quo[0]. Decrement counter; on counter reaching 1, go to FIX. Exactly XLEN cycles.
- FIX (1 cycle): select the result.
  - b==0: quotient = all-ones, remainder = a.
  - Overflow: quotient = 2^(XLEN-1), remainder = 0.
  - Otherwise:
    - quotient is negated if sign(a) XOR sign(b) (signed ops);
    - remainder is negated if sign(a) (signed ops).
  - Register result_o and rd_index_o. Next state DONE.
- DONE: result_valid_o=1 for exactly this cycle, stall_o=0. A new start_i is accepted in the same cycle (back-to-back). Otherwise go to IDLE.
- stall_o = busy_o = (state==CALC || state==FIX). Both are registered, with no combinational path from inputs.
- Latency, normal path: start at cycle 0 → stall cycles 1..XLEN+1 → result_valid_o at cycle XLEN+2 (34 for XLEN=32).
- Latency, special case: valid at cycle 2, stall for 1 cycle.
- flush_i=1:
  - In CALC/FIX: go to IDLE next cycle, stall_o deasserts next cycle, no strobe.
  - In IDLE/DONE: start_i is ignored.
  - flush_i and start_i together: flush wins.
- start_i while busy: ignored; decode is stalled and re-presents the request.
- result_o holds its last value outside the strobe.

Optional Feature:
- Macro DIV_SEQ_EARLY_EXIT_EN.
- When defined, at acceptance with |a| < |b| (unsigned compare of magnitudes, b≠0), skip CALC and go directly to FIX.
  - Quotient = 0; remainder = a (original signed value).
  - Valid at cycle 2.
- When undefined, such operands take the full XLEN-iteration path and produce identical results, only later.

Test Plan:
- DIVU a=100, b=7, start at cycle 0 → stall_o high cycles 1–33; result_valid_o at cycle 34, result_o=14, rd_index_o preserved.
- DIV a=-7 (0xFFFFFFF9), b=2 → quotient 0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1).
- DIVU a=5, b=0 → valid at cycle 2, result 0xFFFFFFFF; REMU a=5, b=0 → result 5; stall_o high cycle 1 only.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same operands → 0.
- DIVU 100/7 with flush_i=1 at cycle 10 → stall_o low from cycle 11, no result_valid_o; a new start at cycle 12 completes at cycle 46.
- Back-to-back: second start presented in the DONE cycle (34) → accepted, second result_valid_o at cycle 68.
- With DIV_SEQ_EARLY_EXIT_EN: DIVU 3/10 → valid at cycle 2, result_o=0.
